// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: memory-stage load/store unit.
// Turns one M-stage access into a single valid/ready bus transaction and
// stalls the pipeline until the response comes back.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (drop misaligned half/word
// accesses and pulse MisalignM instead of accessing the bus).
//
// state | meaning
// IDLE  | waiting for MemReqM; captures the access
// REQ   | bus_req_valid high, waiting for bus_req_ready
// WAIT  | request accepted, waiting for bus_rsp_valid
// DONE  | LoadDoneM pulse, pipeline released for one cycle
module data_mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemReqM,
    input  logic              MemWriteM,
    input  logic [1:0]        MemSizeM,
    input  logic              LoadUnsignedM,
    input  logic [ADDR_W-1:0] AddrM,
    input  logic [31:0]       WriteDataM,
    output logic              StallM,
    output logic [31:0]       ReadDataM,
    output logic              LoadDoneM,
    output logic              MisalignM,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [1:0]  addr_lo;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Byte enables and lane-replicated store data for the incoming access
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteDataM;
        case (MemSizeM)
            2'b00: begin
                be_next    = 4'b0001 << AddrM[1:0];
                wdata_next = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << {AddrM[1], 1'b0};
                wdata_next = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = WriteDataM;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        byte_sel = bus_rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    logic mis_q;

    // Half needs A[0]=0, word (size 10/11) needs A[1:0]=0
    always_comb begin
        misalign = ((MemSizeM == 2'b01) && AddrM[0]) ||
                   (MemSizeM[1] && (AddrM[1:0] != 2'b00));
    end

    assign MisalignM = mis_q;
`else
    assign MisalignM = 1'b0;
`endif

    // Pipeline is held while an access is pending; DONE releases it
    always_comb begin
        StallM = ((state == IDLE) && MemReqM) || (state == REQ) || (state == WAIT);
    end

    // Access sequencer with registered bus and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_be        <= 4'b0000;
            bus_addr      <= '0;
            bus_wdata     <= 32'h0;
            ReadDataM     <= 32'h0;
            LoadDoneM     <= 1'b0;
            addr_lo       <= 2'b00;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (MemReqM) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign) begin
                            state     <= DONE;
                            LoadDoneM <= 1'b1;
                            mis_q     <= 1'b1;
                            ReadDataM <= 32'h0;
                        end else
`endif
                        begin
                            state         <= REQ;
                            bus_req_valid <= 1'b1;
                            bus_addr      <= {AddrM[ADDR_W-1:2], 2'b00};
                            bus_we        <= MemWriteM;
                            bus_be        <= be_next;
                            bus_wdata     <= wdata_next;
                            addr_lo       <= AddrM[1:0];
                            size_q        <= MemSizeM;
                            uns_q         <= LoadUnsignedM;
                        end
                    end
                end
                REQ: begin
                    // a response here would be a fabric protocol error; it is ignored
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_rsp_valid) begin
                        if (!bus_we) begin
                            ReadDataM <= load_ext;
                        end
                        LoadDoneM <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    LoadDoneM <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_q     <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: directed cases plus randomized accesses
// checked against a behavioural model of the access rules.
module tb_data_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        MemReqM;
    logic        MemWriteM;
    logic [1:0]  MemSizeM;
    logic        LoadUnsignedM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        LoadDoneM;
    logic        MisalignM;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;

    data_mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReqM(MemReqM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
        .LoadUnsignedM(LoadUnsignedM), .AddrM(AddrM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .LoadDoneM(LoadDoneM),
        .MisalignM(MisalignM), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // count accepted requests; a response must never overlap a pending request
    always @(posedge clk) begin
        if (rst_n && bus_req_valid && bus_req_ready) hs_cnt++;
        if (rst_n && bus_rsp_valid) chk("rsp_during_req", {31'b0, bus_req_valid}, 32'h0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic bit m_mis(input logic [1:0] size, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size == 2'd1) return (a % 2) != 0;
        if (size >= 2'd2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_be(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd0) return 32'd1 << (a % 4);
        if (size == 2'd1) return 32'd3 << (2 * ((a / 2) % 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd % 256) * 32'h01010101;
        if (size == 2'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] size, input logic uns,
                                          input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rd >> (8 * (a % 4))) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (rd >> (16 * ((a / 2) % 2))) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- one pipeline access ----------------
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int qd, input int rdly);
        int h0;
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = we; MemSizeM = size; LoadUnsignedM = uns;
        AddrM = a; WriteDataM = wd; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        bus_rdata = $urandom;
        h0 = hs_cnt;
        #1;
        chk("idle_stall", {31'b0, StallM}, 32'h1);
        chk("idle_valid", {31'b0, bus_req_valid}, 32'h0);
        if (m_mis(size, a)) begin
            @(negedge clk);
            #1;
            chk("mis_done", {31'b0, LoadDoneM}, 32'h1);
            chk("mis_flag", {31'b0, MisalignM}, 32'h1);
            chk("mis_rdata", ReadDataM, 32'h0);
            chk("mis_stall", {31'b0, StallM}, 32'h0);
            chk("mis_valid", {31'b0, bus_req_valid}, 32'h0);
            @(negedge clk);
            MemReqM = 1'b0;
            #1;
            chk("mis_done_clr", {31'b0, LoadDoneM}, 32'h0);
            chk("mis_flag_clr", {31'b0, MisalignM}, 32'h0);
            chk("mis_no_req", hs_cnt - h0, 32'h0);
            return;
        end
        @(negedge clk);
        for (int k = 0; k <= qd; k++) begin
            bus_req_ready = (k == qd);
            #1;
            chk("req_valid", {31'b0, bus_req_valid}, 32'h1);
            chk("req_addr", bus_addr, a - (a % 4));
            chk("req_we", {31'b0, bus_we}, {31'b0, we});
            chk("req_be", {28'b0, bus_be}, m_be(size, a));
            if (we) chk("req_wdata", bus_wdata, m_wd(size, wd));
            chk("req_stall", {31'b0, StallM}, 32'h1);
            chk("req_misalign", {31'b0, MisalignM}, 32'h0);
            @(negedge clk);
        end
        bus_req_ready = 1'b0;
        for (int k = 0; k <= rdly; k++) begin
            if (k == rdly) begin
                bus_rsp_valid = 1'b1;
                bus_rdata = rd;
            end
            #1;
            chk("wait_valid", {31'b0, bus_req_valid}, 32'h0);
            chk("wait_stall", {31'b0, StallM}, 32'h1);
            chk("wait_done", {31'b0, LoadDoneM}, 32'h0);
            @(negedge clk);
        end
        bus_rsp_valid = 1'b0;
        bus_rdata = $urandom;
        #1;
        chk("done_pulse", {31'b0, LoadDoneM}, 32'h1);
        chk("done_stall", {31'b0, StallM}, 32'h0);
        chk("done_misalign", {31'b0, MisalignM}, 32'h0);
        if (!we) chk("load_data", ReadDataM, m_rd(size, uns, a, rd));
        chk("one_txn", hs_cnt - h0, 32'h1);
        @(negedge clk);
        MemReqM = 1'b0;
        #1;
        chk("done_clr", {31'b0, LoadDoneM}, 32'h0);
        chk("after_stall", {31'b0, StallM}, 32'h0);
    endtask

    // ---------------- async reset mid-transaction ----------------
    task automatic mid_reset(input bit in_wait);
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'd2; LoadUnsignedM = 1'b0;
        AddrM = 32'h300; WriteDataM = 32'h0;
        bus_req_ready = in_wait; bus_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_pre_valid", {31'b0, bus_req_valid}, 32'h1);
        if (in_wait) begin
            @(negedge clk);
            bus_req_ready = 1'b0;
            #1;
            chk("rst_pre_wait_stall", {31'b0, StallM}, 32'h1);
        end
        rst_n = 1'b0;
        MemReqM = 1'b0;
        #1;
        chk("rst_valid", {31'b0, bus_req_valid}, 32'h0);
        chk("rst_stall", {31'b0, StallM}, 32'h0);
        chk("rst_done", {31'b0, LoadDoneM}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        #1;
        chk("late_rsp_done", {31'b0, LoadDoneM}, 32'h0);
        chk("late_rsp_stall", {31'b0, StallM}, 32'h0);
        @(negedge clk);
        #1;
        chk("late_rsp_done2", {31'b0, LoadDoneM}, 32'h0);
        chk("late_rsp_rdata", ReadDataM, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; MemSizeM = 2'd0;
        LoadUnsignedM = 1'b0; AddrM = 32'h0; WriteDataM = 32'h0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        #12;
        chk("rst_req_valid", {31'b0, bus_req_valid}, 32'h0);
        chk("rst_we", {31'b0, bus_we}, 32'h0);
        chk("rst_be", {28'b0, bus_be}, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_loaddone", {31'b0, LoadDoneM}, 32'h0);
        chk("rst_misalign", {31'b0, MisalignM}, 32'h0);
        chk("rst_stallm", {31'b0, StallM}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw, zero-wait
        do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        // lb / lbu from top lane
        do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, 0);
        do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, 0);
        // sh upper half
        do_access(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 0, 0);
        // lh signed from upper half, size 11 treated as word
        do_access(1'b0, 2'd1, 1'b0, 32'h402, 32'h0, 32'h9ABC0000, 0, 0);
        do_access(1'b0, 2'd3, 1'b0, 32'h404, 32'h0, 32'h13572468, 0, 1);
        // fabric back-pressure for 5 cycles
        do_access(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h0BADF00D, 5, 0);
        // reset while in REQ, then while in WAIT
        mid_reset(1'b0);
        mid_reset(1'b1);
        // misaligned word: trapped or aligned down depending on build
        do_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h11223344, 0, 0);
        do_access(1'b1, 2'd1, 1'b0, 32'h603, 32'h0000BEEF, 32'h0, 1, 0);

        for (int i = 0; i < 40; i++) begin
            do_access($urandom % 2, $urandom % 4, $urandom % 2, $urandom,
                      $urandom, $urandom, $urandom % 3, $urandom % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
